// File: rtl/jts18_vdp_mix.sv
// System 16 / VDP colour mixer: aligns pixels with the late vdp_sel decision and picks the output layer.
// Define JTS18_VDPMIX_STATS_EN to build the per-frame VDP pixel counter on vdp_cnt.
module jts18_vdp_mix #(
  parameter int DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [14:0] s16_rgb,
  input  logic [14:0] vdp_rgb,
  input  logic        vdp_sel,
  input  logic        vdp_en,
  output logic [14:0] rgb_out,
  output logic        LHBL_out,
  output logic        LVBL_out,
  output logic [16:0] vdp_cnt
);

  logic [31:0] w_pix_in;
  logic [31:0] w_pix_dly;
  logic [14:0] w_s16_d;
  logic [14:0] w_vdp_d;
  logic        w_lhbl_d;
  logic        w_lvbl_d;
  logic        w_blank;
  logic        w_use_vdp;

  assign w_pix_in = {s16_rgb, vdp_rgb, LHBL, LVBL};

  // The delay line runs on every clk so vdp_sel lines up with its pixel no matter where pxl_cen falls.
  generate
    if (DLY == 0) begin : g_bypass
      assign w_pix_dly = w_pix_in;
    end else begin : g_pipe
      logic [31:0] r_pipe [DLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_pix_in;
          for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_pix_dly = r_pipe[DLY-1];
    end
  endgenerate

  assign {w_s16_d, w_vdp_d, w_lhbl_d, w_lvbl_d} = w_pix_dly;
  assign w_blank   = ~(w_lhbl_d & w_lvbl_d);
  assign w_use_vdp = vdp_sel & vdp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out  <= '0;
      LHBL_out <= 1'b0;
      LVBL_out <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_out <= w_lhbl_d;
      LVBL_out <= w_lvbl_d;
      if (w_blank) rgb_out <= '0;
      else if (w_use_vdp) rgb_out <= w_vdp_d;
      else rgb_out <= w_s16_d;
    end
  end

`ifdef JTS18_VDPMIX_STATS_EN
  logic [16:0] r_cnt;
  logic [16:0] r_vdp_cnt;
  logic        r_lvbl_last;
  logic        w_vb_fall;
  logic        w_count;

  // Edge detect runs every clk; a falling LVBL between pixel enables still closes the frame.
  assign w_vb_fall = r_lvbl_last & ~w_lvbl_d;
  assign w_count   = pxl_cen & w_lhbl_d & w_lvbl_d & w_use_vdp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_vdp_cnt   <= '0;
      r_lvbl_last <= 1'b0;
    end else begin
      r_lvbl_last <= w_lvbl_d;
      if (w_vb_fall) begin
        r_vdp_cnt <= r_cnt;
        r_cnt     <= '0;
      end else if (w_count && (r_cnt != 17'h1FFFF)) begin
        r_cnt <= r_cnt + 17'd1;
      end
    end
  end

  assign vdp_cnt = r_vdp_cnt;
`else
  assign vdp_cnt = '0;
`endif

endmodule

// File: tb/tb_jts18_vdp_mix.sv
// Bench for jts18_vdp_mix: directed and random pixels against a queue-based delay/mix model.
module tb_jts18_vdp_mix;
  localparam int DLY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        LHBL = 1'b0;
  logic        LVBL = 1'b0;
  logic [14:0] s16_rgb = '0;
  logic [14:0] vdp_rgb = '0;
  logic        vdp_sel = 1'b0;
  logic        vdp_en = 1'b0;
  logic [14:0] rgb_out;
  logic        LHBL_out;
  logic        LVBL_out;
  logic [16:0] vdp_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [14:0] s16;
    logic [14:0] vdp;
    logic        lh;
    logic        lv;
  } pix_t;

  pix_t        hist[$];
  logic [14:0] m_rgb;
  logic        m_lh;
  logic        m_lv;

  jts18_vdp_mix #(.DLY(DLY)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .s16_rgb(s16_rgb), .vdp_rgb(vdp_rgb), .vdp_sel(vdp_sel), .vdp_en(vdp_en),
    .rgb_out(rgb_out), .LHBL_out(LHBL_out), .LVBL_out(LVBL_out), .vdp_cnt(vdp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (DLY) hist.push_back('0);
    m_rgb = '0;
    m_lh  = 1'b0;
    m_lv  = 1'b0;
  endtask

  // One clk edge: capture what the DUT sees, advance the model, compare just after the edge.
  task automatic tick();
    pix_t cur;
    pix_t d;
    logic cen, sel, en, r;
    cur = {s16_rgb, vdp_rgb, LHBL, LVBL};
    cen = pxl_cen;
    sel = vdp_sel;
    en  = vdp_en;
    r   = rst;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      hist.push_back(cur);
      d = hist.pop_front();
      if (cen) begin
        m_lh  = d.lh;
        m_lv  = d.lv;
        m_rgb = (!d.lh || !d.lv) ? 15'd0 : ((sel && en) ? d.vdp : d.s16);
      end
    end
    check("rgb_out", 32'(rgb_out), 32'(m_rgb));
    check("LHBL_out", 32'(LHBL_out), 32'(m_lh));
    check("LVBL_out", 32'(LVBL_out), 32'(m_lv));
`ifndef JTS18_VDPMIX_STATS_EN
    check("vdp_cnt_off", 32'(vdp_cnt), 32'd0);
`endif
  endtask

  task automatic rand_pix();
    s16_rgb = 15'($urandom);
    vdp_rgb = 15'($urandom);
  endtask

`ifdef JTS18_VDPMIX_STATS_EN
  // Selected pixels are the last n_sel of the frame so the final visible pixel is always included.
  task automatic frame(input int n_pix, input int n_sel, input logic [16:0] exp_cnt, input string tag);
    LHBL = 1'b1; LVBL = 1'b0; vdp_sel = 1'b0; vdp_en = 1'b1; pxl_cen = 1'b1;
    repeat (DLY + 2) tick();
    for (int e = 0; e < n_pix + DLY + 4; e++) begin
      LVBL    = (e < n_pix);
      vdp_sel = (e >= DLY) && (e - DLY < n_pix) && (e - DLY >= n_pix - n_sel);
      rand_pix();
      tick();
    end
    check(tag, 32'(vdp_cnt), 32'(exp_cnt));
  endtask
`endif

  initial begin
    model_reset();
    repeat (3) tick();
    check("reset_vdp_cnt", 32'(vdp_cnt), 32'd0);

    rst = 1'b0;
    LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
    s16_rgb = 15'h1234; vdp_rgb = 15'h7FFF; vdp_en = 1'b1; vdp_sel = 1'b0;
    repeat (DLY) tick();
    vdp_sel = 1'b1;
    tick();
    check("vdp_path", 32'(rgb_out), 32'h7FFF);
    vdp_sel = 1'b0;
    tick();
    check("s16_path", 32'(rgb_out), 32'h1234);

    vdp_en = 1'b0; vdp_sel = 1'b1; s16_rgb = 15'h0421;
    repeat (DLY + 1) tick();
    check("vdp_en_off", 32'(rgb_out), 32'h0421);

    s16_rgb = 15'h7C00;
    repeat (DLY + 1) tick();
    check("pre_blank", 32'(rgb_out), 32'h7C00);
    LHBL = 1'b0;
    tick();
    LHBL = 1'b1;
    repeat (DLY - 1) tick();
    check("blank_not_yet", 32'(rgb_out), 32'h7C00);
    tick();
    check("blank_rgb", 32'(rgb_out), 32'h0);
    check("blank_lhbl", 32'(LHBL_out), 32'h0);
    tick();
    check("post_blank", 32'(rgb_out), 32'h7C00);

    vdp_en = 1'b1; LHBL = 1'b0;
    repeat (DLY) tick();
    vdp_sel = 1'bx;
    repeat (2) tick();
    check("blank_sel_x", 32'(rgb_out), 32'h0);
    LHBL = 1'b1; vdp_sel = 1'b0;

    for (int c = 0; c < 96; c++) begin
      if (c % 4 == 0) begin
        rand_pix();
        vdp_sel = 1'($urandom_range(0, 1));
      end
      pxl_cen = (c % 4 == 3);
      tick();
    end

    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) vdp_en = 1'($urandom_range(0, 1));
      pxl_cen = 1'($urandom_range(0, 1));
      LHBL    = ($urandom_range(0, 9) != 0);
      LVBL    = ($urandom_range(0, 19) != 0);
      vdp_sel = 1'($urandom_range(0, 1));
      rand_pix();
      tick();
    end

`ifdef JTS18_VDPMIX_STATS_EN
    frame(320 * 224, 1000, 17'd1000, "frame_1000");
    frame(320 * 16, 0, 17'd0, "frame_empty");
    frame(512 * 256, 512 * 256, 17'h1FFFF, "frame_saturate");
`endif

    LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1; vdp_en = 1'b1;
    repeat (5) begin
      rand_pix();
      vdp_sel = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    pxl_cen = 1'b0;
    tick();
    check("midline_rst_rgb", 32'(rgb_out), 32'h0);
    check("midline_rst_cnt", 32'(vdp_cnt), 32'h0);
    rst = 1'b0;
    pxl_cen = 1'b1;
    for (int i = 0; i < DLY; i++) begin
      s16_rgb = 15'h7FFF; vdp_rgb = 15'h7FFF;
      tick();
      check("post_rst_zero", 32'(rgb_out), 32'h0);
    end
    for (int c = 0; c < 60; c++) begin
      pxl_cen = 1'($urandom_range(0, 1));
      vdp_sel = 1'($urandom_range(0, 1));
      rand_pix();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
